// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stall/flush outputs of the pipeline sequencer, grouped as one bundle.
// master = pipeline/hazard side, slave = pipeline_ctrl.
interface pipeline_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic             load_use;
   logic             br_taken;
   logic             mem_req;
   logic             mem_ready;
   logic             md_start;
   logic             md_done;
   logic             md_go;
   logic             pc_we;
   logic             if_id_we;
   logic             id_ex_we;
   logic             ex_mem_we;
   logic             mem_wb_we;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             ex_mem_flush;
   logic             mem_wb_flush;
   logic             md_timeout;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output load_use, br_taken, mem_req, mem_ready, md_start, md_done,
      input  md_go, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
      input  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
      input  md_timeout, state, stall_cnt, flush_cnt
   );

   modport slave (
      input  load_use, br_taken, mem_req, mem_ready, md_start, md_done,
      output md_go, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
      output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
      output md_timeout, state, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: prioritises hazards, tracks mul/div
// occupancy with a watchdog, and keeps saturating stall/flush counters.
module pipeline_ctrl #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned MD_TIMEOUT = 40
) (
   input logic            clk_i,
   input logic            rst_ni,
   pipeline_ctrl_if.slave bus
);

   localparam logic [1:0] StRun    = 2'd0;
   localparam logic [1:0] StMdWait = 2'd1;
   localparam logic [1:0] StMdDone = 2'd2;
   localparam int unsigned MdCntW  = $clog2(MD_TIMEOUT + 1);

   logic [1:0]        state_q, state_d;
   logic [MdCntW-1:0] md_cnt_q, md_cnt_d;
   logic              md_timeout_q, md_timeout_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic mem_stall, md_stall, md_go;
   logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
   logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;

   always_comb begin
      mem_stall    = bus.mem_req & ~bus.mem_ready;
      md_stall     = ((state_q == StRun) & bus.md_start) |
                     ((state_q == StMdWait) & ~bus.md_done);
      md_go        = (state_q == StRun) & bus.md_start & ~mem_stall;
      pc_we        = 1'b1;
      if_id_we     = 1'b1;
      id_ex_we     = 1'b1;
      ex_mem_we    = 1'b1;
      mem_wb_we    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
      // Exactly one hazard class acts per cycle; EX is frozen by the higher ones.
      if (mem_stall) begin
         pc_we        = 1'b0;
         if_id_we     = 1'b0;
         id_ex_we     = 1'b0;
         ex_mem_we    = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (md_stall) begin
         pc_we        = 1'b0;
         if_id_we     = 1'b0;
         id_ex_we     = 1'b0;
         ex_mem_flush = 1'b1;
      end else if (bus.br_taken) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
      end else if (bus.load_use) begin
         pc_we        = 1'b0;
         if_id_we     = 1'b0;
         id_ex_flush  = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      md_cnt_d     = md_cnt_q;
      md_timeout_d = md_timeout_q;
      case (state_q)
         StRun: begin
            if (md_go) begin
               state_d  = StMdWait;
               md_cnt_d = '0;
            end
         end
         StMdWait: begin
            md_cnt_d = md_cnt_q + MdCntW'(1);
            if (bus.md_done) begin
               state_d = mem_stall ? StMdDone : StRun;
            end else if (md_cnt_q == MdCntW'(MD_TIMEOUT - 1)) begin
               md_timeout_d = 1'b1;
               state_d      = StRun;
            end
         end
         StMdDone: begin
            if (!mem_stall) state_d = StRun;
         end
         default: state_d = StRun;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_we && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (if_id_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StRun;
         md_cnt_q     <= '0;
         md_timeout_q <= 1'b0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         md_cnt_q     <= md_cnt_d;
         md_timeout_q <= md_timeout_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   // Outputs are combinational, so hold them at the idle pattern while reset is asserted.
   always_comb begin
      bus.md_go        = rst_ni & md_go;
      bus.pc_we        = ~rst_ni | pc_we;
      bus.if_id_we     = ~rst_ni | if_id_we;
      bus.id_ex_we     = ~rst_ni | id_ex_we;
      bus.ex_mem_we    = ~rst_ni | ex_mem_we;
      bus.mem_wb_we    = ~rst_ni | mem_wb_we;
      bus.if_id_flush  = rst_ni & if_id_flush;
      bus.id_ex_flush  = rst_ni & id_ex_flush;
      bus.ex_mem_flush = rst_ni & ex_mem_flush;
      bus.mem_wb_flush = rst_ni & mem_wb_flush;
      bus.md_timeout   = md_timeout_q;
      bus.state        = state_q;
      bus.stall_cnt    = stall_cnt_q;
      bus.flush_cnt    = flush_cnt_q;
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed hazard scenarios plus random traffic, checked
// against a transaction-level model of the mul/div unit and the hazard priority table.
module tb_pipeline_ctrl;

   localparam int unsigned CNT_W      = 4;
   localparam int unsigned MD_TIMEOUT = 40;
   localparam int          CMAX       = (1 << CNT_W) - 1;

   typedef struct {
      logic       go;
      logic [4:0] we;
      logic [3:0] fl;
      logic       to;
      logic [1:0] st;
      int         sc;
      int         fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;

   pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipeline_ctrl #(.CNT_W(CNT_W), .MD_TIMEOUT(MD_TIMEOUT)) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model: mul/div op outstanding, result parked behind a memory stall, cycles waited.
   bit m_busy, m_held, m_to, md_hold;
   int m_wait, m_sc, m_fc;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // {pc, if_id, id_ex, ex_mem, mem_wb} enables and {if_id, id_ex, ex_mem, mem_wb} flushes.
   function automatic logic [8:0] resp(input int reason);
      case (reason)
         1:       return {5'b00001, 4'b0001};
         2:       return {5'b00011, 4'b0010};
         3:       return {5'b11111, 4'b1100};
         4:       return {5'b00111, 4'b0100};
         default: return {5'b11111, 4'b0000};
      endcase
   endfunction

   task automatic cycle(input bit rst, input bit lu, input bit br, input bit req,
                        input bit rdy, input bit start, input bit done);
      exp_t       e;
      bit         st_eff, ms, mds, go, idle;
      int         reason;
      logic [8:0] r;
      @(posedge clk);
      #1;
      st_eff        = start | md_hold;
      bus.load_use  = lu;
      bus.br_taken  = br;
      bus.mem_req   = req;
      bus.mem_ready = rdy;
      bus.md_start  = st_eff;
      bus.md_done   = done;
      if (rst) begin
         rst_ni = 1'b0;
         e.go = 1'b0; e.we = 5'b11111; e.fl = 4'b0000; e.to = 1'b0; e.st = 2'd0;
         e.sc = 0; e.fc = 0;
         sb.push_back(e);
         m_busy = 0; m_held = 0; m_to = 0; md_hold = 0; m_wait = 0; m_sc = 0; m_fc = 0;
         return;
      end
      rst_ni = 1'b1;
      idle   = !m_busy && !m_held;
      ms     = req && !rdy;
      mds    = (idle && st_eff) || (m_busy && !done);
      go     = idle && st_eff && !ms;
      reason = ms ? 1 : mds ? 2 : br ? 3 : lu ? 4 : 0;
      r      = resp(reason);
      e.go = go; e.we = r[8:4]; e.fl = r[3:0]; e.to = m_to;
      e.st = m_busy ? 2'd1 : (m_held ? 2'd2 : 2'd0);
      e.sc = m_sc; e.fc = m_fc;
      sb.push_back(e);
      if (!e.we[4] && m_sc < CMAX) m_sc++;
      if (e.fl[3] && m_fc < CMAX) m_fc++;
      if (go) begin
         m_busy = 1; m_wait = 0;
      end else if (m_busy) begin
         m_wait++;
         if (done) begin
            m_busy = 0; m_held = ms;
         end else if (m_wait == MD_TIMEOUT) begin
            m_busy = 0; m_to = 1;
         end
      end else if (m_held && !ms) begin
         m_held = 0;
      end
      md_hold = st_eff && idle && !go;
   endtask

   task automatic idle_cycle();
      cycle(0, 0, 0, 0, 0, 0, 0);
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         chk("md_go", int'(bus.md_go), int'(mon_e.go));
         chk("we", int'({bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we, bus.mem_wb_we}),
             int'(mon_e.we));
         chk("flush", int'({bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush,
                            bus.mem_wb_flush}), int'(mon_e.fl));
         chk("md_timeout", int'(bus.md_timeout), int'(mon_e.to));
         chk("state", int'(bus.state), int'(mon_e.st));
         chk("stall_cnt", int'(bus.stall_cnt), mon_e.sc);
         chk("flush_cnt", int'(bus.flush_cnt), mon_e.fc);
      end
   end

   initial begin
      bus.load_use = 0; bus.br_taken = 0; bus.mem_req = 0;
      bus.mem_ready = 0; bus.md_start = 0; bus.md_done = 0;
      cycle(1, 1, 1, 1, 0, 1, 0);
      @(negedge clk);
      chk("reset_pc_we", int'(bus.pc_we), 1);

      // Single load-use bubble
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0);
      idle_cycle();
      @(negedge clk);
      chk("t1_stall_cnt", int'(bus.stall_cnt), 1);

      // Branch kills the load-use victim
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 1, 0, 0, 0, 0);
      idle_cycle();
      @(negedge clk);
      chk("t2_flush_cnt", int'(bus.flush_cnt), 1);
      chk("t2_stall_cnt", int'(bus.stall_cnt), 0);

      // Mul/div completes after four wait cycles
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 1, 0);
      repeat (4) idle_cycle();
      cycle(0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk("t3_stall_cnt", int'(bus.stall_cnt), 5);
      idle_cycle();
      @(negedge clk);
      chk("t3_state_run", int'(bus.state), 0);

      // Result arrives under a 3-cycle memory stall
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 1, 0);
      repeat (2) idle_cycle();
      cycle(0, 0, 0, 1, 0, 0, 1);
      repeat (2) cycle(0, 0, 0, 1, 0, 0, 0);
      @(negedge clk);
      chk("t4_state_done", int'(bus.state), 2);
      repeat (2) idle_cycle();

      // Watchdog
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 1, 0);
      repeat (MD_TIMEOUT) idle_cycle();
      idle_cycle();
      @(negedge clk);
      chk("t5_timeout", int'(bus.md_timeout), 1);
      chk("t5_state_run", int'(bus.state), 0);
      cycle(0, 0, 0, 0, 0, 1, 0);
      repeat (3) idle_cycle();
      cycle(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t5_reset_timeout", int'(bus.md_timeout), 0);

      // Counter saturation, then memory stall swallowing a branch
      repeat (20) cycle(0, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t6_stall_sat", int'(bus.stall_cnt), CMAX);
      cycle(0, 0, 1, 1, 0, 0, 0);
      @(negedge clk);
      chk("t6_no_if_id_flush", int'(bus.if_id_flush), 0);

      cycle(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         bit rst, lu, br, req, rdy, start, done;
         rst   = ($urandom_range(0, 199) == 0);
         lu    = ($urandom_range(0, 3) == 0);
         br    = ($urandom_range(0, 4) == 0);
         req   = ($urandom_range(0, 1) == 0);
         rdy   = ($urandom_range(0, 1) == 0);
         start = !m_busy && !m_held && ($urandom_range(0, 5) == 0);
         done  = m_busy ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0);
         cycle(rst, lu, br, req, rdy, start, done);
      end

      for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
